// File: rtl/branch_predictor_table_if.sv
// Prediction (IF side) and resolve (EX side) signals of the branch predictor table.
// master = pipeline, slave = predictor.
interface branch_predictor_table_if #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6
);
  logic [PC_W-1:0]  pred_pc;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic             upd_mispredict;

  modport master (
    output pred_pc, upd_valid, upd_idx, upd_taken, upd_mispredict,
    input  pred_taken, pred_idx
  );

  modport slave (
    input  pred_pc, upd_valid, upd_idx, upd_taken, upd_mispredict,
    output pred_taken, pred_idx
  );
endinterface

// File: rtl/branch_predictor_table.sv
// Table of saturating counters indexed by PC (bimodal) or PC^history (gshare),
// with a post-reset init sweep and saturating branch/mispredict statistics.
module branch_predictor_table #(
  parameter int PC_W  = 32,
  parameter int IDX_W = 6,
  parameter int CTR_W = 2,
  parameter int GHR_W = 6,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   clr_stats,
  branch_predictor_table_if.slave bp,
  output logic                   init_busy,
  output logic [CNT_W-1:0]       br_cnt,
  output logic [CNT_W-1:0]       mis_cnt
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CTR_W-1:0] WEAK_NT = {1'b0, {(CTR_W-1){1'b1}}};

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] ptr, ptr_nxt;
  logic [CTR_W-1:0] tbl [ENTRIES];
  logic [GHR_W-1:0] ghr;
  logic [IDX_W-1:0] pc_idx, idx;
  logic [CTR_W-1:0] cur, nxt;
  logic             upd_en;
  logic             unused_pc;

  assign pc_idx    = bp.pred_pc[IDX_W+1:2];
  assign idx       = (MODE == 1) ? (pc_idx ^ IDX_W'(ghr)) : pc_idx;
  assign unused_pc = ^{bp.pred_pc[PC_W-1:IDX_W+2], bp.pred_pc[1:0]};

  // No read/write bypass: a same-cycle update to idx shows up one cycle later.
  assign bp.pred_idx   = idx;
  assign bp.pred_taken = ~init_busy & tbl[idx][CTR_W-1];

  assign upd_en = (state == RUN) & bp.upd_valid & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    init_busy = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        ptr_nxt   = ptr + 1'b1;
        if (ptr == '1) state_nxt = RUN;
      end
      default: ;
    endcase
  end

  always_comb begin
    cur = tbl[bp.upd_idx];
    nxt = cur;
    if (bp.upd_taken && cur != '1)       nxt = cur + 1'b1;
    else if (!bp.upd_taken && cur != '0) nxt = cur - 1'b1;
  end

  // Table contents need no reset: the sweep rewrites every entry before use.
  always_ff @(posedge clk) begin
    if (state == INIT)  tbl[ptr]        <= WEAK_NT;
    else if (upd_en)    tbl[bp.upd_idx] <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr     <= '0;
      br_cnt  <= '0;
      mis_cnt <= '0;
    end else begin
      if (upd_en) ghr <= {ghr[GHR_W-2:0], bp.upd_taken};
      if (clr_stats) begin
        br_cnt  <= '0;
        mis_cnt <= '0;
      end else if (upd_en) begin
        if (br_cnt != '1) br_cnt <= br_cnt + 1'b1;
        if (bp.upd_mispredict && mis_cnt != '1) mis_cnt <= mis_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor_table.sv
// Bench for branch_predictor_table: a bimodal/CNT_W=4 instance and a gshare/CNT_W=16
// instance share all stimulus; expected values come from a reference model.
module tb_branch_predictor_table;
  logic clk = 1'b0;
  logic rst, stall, clr_stats;
  logic busy0, busy1;
  logic [3:0]  br0, mis0;
  logic [15:0] br1, mis1;

  always #5 clk = ~clk;

  branch_predictor_table_if #(.PC_W(32), .IDX_W(6)) bi0 (), bi1 ();

  assign bi1.pred_pc        = bi0.pred_pc;
  assign bi1.upd_valid      = bi0.upd_valid;
  assign bi1.upd_idx        = bi0.upd_idx;
  assign bi1.upd_taken      = bi0.upd_taken;
  assign bi1.upd_mispredict = bi0.upd_mispredict;

  branch_predictor_table #(.PC_W(32), .IDX_W(6), .CTR_W(2), .GHR_W(6), .MODE(0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .stall(stall), .clr_stats(clr_stats), .bp(bi0),
    .init_busy(busy0), .br_cnt(br0), .mis_cnt(mis0));

  branch_predictor_table #(.PC_W(32), .IDX_W(6), .CTR_W(2), .GHR_W(6), .MODE(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .stall(stall), .clr_stats(clr_stats), .bp(bi1),
    .init_busy(busy1), .br_cnt(br1), .mis_cnt(mis1));

  int checks = 0;
  int errors = 0;
  int mtab [64];
  int mghr, mbr0, mmis0, mbr1, mmis1;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  function automatic logic [31:0] mpred(input int i);
    return (mtab[i] >= 2) ? 32'd1 : 32'd0;
  endfunction

  function automatic logic [31:0] midx1(input logic [31:0] pc);
    return ((pc >> 2) & 32'd63) ^ 32'(mghr);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) mtab[i] = 1;
    mghr = 0; mbr0 = 0; mmis0 = 0; mbr1 = 0; mmis1 = 0;
  endtask

  task automatic drive(input logic [31:0] pc, input bit uv, input int ui, input bit ut,
                       input bit um, input bit st, input bit clr);
    @(negedge clk);
    bi0.pred_pc = pc; bi0.upd_valid = uv; bi0.upd_idx = ui[5:0];
    bi0.upd_taken = ut; bi0.upd_mispredict = um; stall = st; clr_stats = clr;
  endtask

  // Advance the model by what the upcoming posedge applies (RUN state assumed).
  task automatic commit();
    int i;
    i = int'(bi0.upd_idx);
    if (bi0.upd_valid && !stall) begin
      if (bi0.upd_taken) mtab[i] = (mtab[i] == 3) ? 3 : mtab[i] + 1;
      else               mtab[i] = (mtab[i] == 0) ? 0 : mtab[i] - 1;
      mghr = ((mghr << 1) | int'(bi0.upd_taken)) & 63;
      if (!clr_stats) begin
        mbr0 = (mbr0 == 15) ? 15 : mbr0 + 1;
        mbr1 = (mbr1 == 65535) ? 65535 : mbr1 + 1;
        if (bi0.upd_mispredict) begin
          mmis0 = (mmis0 == 15) ? 15 : mmis0 + 1;
          mmis1 = (mmis1 == 65535) ? 65535 : mmis1 + 1;
        end
      end
    end
    if (clr_stats) begin mbr0 = 0; mmis0 = 0; mbr1 = 0; mmis1 = 0; end
  endtask

  // Called at the negedge where rst has just dropped; counts busy cycles from there.
  task automatic count_busy(output int n, output bit pt_bad);
    n = 0; pt_bad = 1'b0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (!busy0) break;
      n++;
      if (bi0.pred_taken !== 1'b0 || bi1.pred_taken !== 1'b0) pt_bad = 1'b1;
      @(negedge clk);
      bi0.pred_pc = $urandom;
    end
  endtask

  task automatic test_reset();
    int n; bit pt_bad;
    drive(32'h0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'd64);
    count_busy(n, pt_bad);
    e = exp_q.pop_front(); checks++;
    if (32'(n) !== e) begin errors++; $display("FAIL reset_busy_cycles got %0d want %0d", n, e); end
    checks++;
    if (pt_bad) begin errors++; $display("FAIL reset_pred_during_init got 1 want 0"); end
    model_reset();
    for (int i = 0; i < 64; i++) begin
      drive(32'(i << 2), 0, 0, 0, 0, 0, 0);
      exp_q.push_back(mpred(i));
      exp_q.push_back(32'(i));
      #1;
      e = exp_q.pop_front(); checks++;
      if (32'(bi0.pred_taken) !== e) begin errors++; $display("FAIL init_entry%0d_taken got %0d want %0d", i, bi0.pred_taken, e); end
      e = exp_q.pop_front(); checks++;
      if (32'(bi0.pred_idx) !== e) begin errors++; $display("FAIL init_entry%0d_idx got %0d want %0d", i, bi0.pred_idx, e); end
      commit();
    end
    exp_q.push_back(32'(mbr0));
    exp_q.push_back(32'(mmis1));
    e = exp_q.pop_front(); checks++;
    if (32'(br0) !== e) begin errors++; $display("FAIL reset_br_cnt got %0d want %0d", br0, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(mis1) !== e) begin errors++; $display("FAIL reset_mis_cnt got %0d want %0d", mis1, e); end
  endtask

  task automatic test_stall();
    for (int c = 0; c < 5; c++) begin
      drive(32'(3 << 2), 1, 3, 1, 1, 1, 0);
      exp_q.push_back(mpred(3));
      #1;
      e = exp_q.pop_front(); checks++;
      if (32'(bi0.pred_taken) !== e) begin errors++; $display("FAIL stall_pred c%0d got %0d want %0d", c, bi0.pred_taken, e); end
      commit();
    end
    drive(32'(3 << 2), 0, 0, 0, 0, 0, 0);
    exp_q.push_back(mpred(3));
    exp_q.push_back(32'(mbr0));
    exp_q.push_back(32'(mbr1));
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(bi0.pred_taken) !== e) begin errors++; $display("FAIL stall_idx3_after got %0d want %0d", bi0.pred_taken, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(br0) !== e) begin errors++; $display("FAIL stall_br_cnt0 got %0d want %0d", br0, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(br1) !== e) begin errors++; $display("FAIL stall_br_cnt1 got %0d want %0d", br1, e); end
    commit();
    drive(32'h40, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(midx1(32'h40));
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(bi1.pred_idx) !== e) begin errors++; $display("FAIL stall_ghr_idx got %0d want %0d", bi1.pred_idx, e); end
    commit();
  endtask

  task automatic test_saturation();
    bit pat [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0};
    for (int c = 0; c < 11; c++) begin
      drive(32'h40, (c < 10), 16, pat[c], 0, 0, 0);
      exp_q.push_back(mpred(16));
      exp_q.push_back(32'd16);
      #1;
      e = exp_q.pop_front(); checks++;
      if (32'(bi0.pred_taken) !== e) begin errors++; $display("FAIL sat_step%0d_taken got %0d want %0d", c, bi0.pred_taken, e); end
      e = exp_q.pop_front(); checks++;
      if (32'(bi0.pred_idx) !== e) begin errors++; $display("FAIL sat_step%0d_idx got %0d want %0d", c, bi0.pred_idx, e); end
      commit();
    end
  endtask

  task automatic test_collision();
    for (int c = 0; c < 2; c++) begin
      drive(32'(5 << 2), (c == 0), 5, 1, 0, 0, 0);
      exp_q.push_back(mpred(5));
      #1;
      e = exp_q.pop_front(); checks++;
      if (32'(bi0.pred_taken) !== e) begin errors++; $display("FAIL collision_c%0d got %0d want %0d", c, bi0.pred_taken, e); end
      commit();
    end
  endtask

  task automatic test_stats();
    drive(32'h0, 0, 0, 0, 0, 0, 1);
    commit();
    for (int i = 0; i < 20; i++) begin
      drive(32'h0, 1, 40, i[0], (i % 3 == 0), 0, 0);
      commit();
    end
    drive(32'h0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(32'(mbr0)); exp_q.push_back(32'(mmis0));
    exp_q.push_back(32'(mbr1)); exp_q.push_back(32'(mmis1));
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(br0) !== e) begin errors++; $display("FAIL stats_br_sat got %0d want %0d", br0, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(mis0) !== e) begin errors++; $display("FAIL stats_mis got %0d want %0d", mis0, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(br1) !== e) begin errors++; $display("FAIL stats_br_wide got %0d want %0d", br1, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(mis1) !== e) begin errors++; $display("FAIL stats_mis_wide got %0d want %0d", mis1, e); end
    commit();
    drive(32'h0, 1, 41, 1, 1, 0, 1);
    commit();
    drive(32'h0, 0, 0, 0, 0, 0, 0);
    exp_q.push_back(32'(mbr0)); exp_q.push_back(32'(mmis0));
    exp_q.push_back(32'(mbr1)); exp_q.push_back(32'(mmis1));
    #1;
    e = exp_q.pop_front(); checks++;
    if (32'(br0) !== e) begin errors++; $display("FAIL clr_br0 got %0d want %0d", br0, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(mis0) !== e) begin errors++; $display("FAIL clr_mis0 got %0d want %0d", mis0, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(br1) !== e) begin errors++; $display("FAIL clr_br1 got %0d want %0d", br1, e); end
    e = exp_q.pop_front(); checks++;
    if (32'(mis1) !== e) begin errors++; $display("FAIL clr_mis1 got %0d want %0d", mis1, e); end
    commit();
  endtask

  task automatic test_gshare();
    int n; bit pt_bad;
    logic [31:0] pcs [2] = '{32'h40, 32'h7c};
    drive(32'h0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 29; k++) @(negedge clk);
    #1;
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL midinit_busy_c30 got %0b want 1", busy0); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'd64);
    count_busy(n, pt_bad);
    e = exp_q.pop_front(); checks++;
    if (32'(n) !== e) begin errors++; $display("FAIL midinit_busy_cycles got %0d want %0d", n, e); end
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL midinit_busy1_end got %0b want 0", busy1); end
    model_reset();
    for (int c = 0; c < 2; c++) begin
      drive(32'h0, 1, 0, 1, 0, 0, 0);
      commit();
    end
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 2; p++) begin
        drive(pcs[p], 0, 0, 0, 0, 0, 0);
        exp_q.push_back(midx1(pcs[p]));
        exp_q.push_back((pcs[p] >> 2) & 32'd63);
        exp_q.push_back(mpred(int'(midx1(pcs[p]))));
        #1;
        e = exp_q.pop_front(); checks++;
        if (32'(bi1.pred_idx) !== e) begin errors++; $display("FAIL gshare_idx r%0d p%0d got %0d want %0d", r, p, bi1.pred_idx, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(bi0.pred_idx) !== e) begin errors++; $display("FAIL bimodal_idx r%0d p%0d got %0d want %0d", r, p, bi0.pred_idx, e); end
        e = exp_q.pop_front(); checks++;
        if (32'(bi1.pred_taken) !== e) begin errors++; $display("FAIL gshare_taken r%0d p%0d got %0d want %0d", r, p, bi1.pred_taken, e); end
        commit();
      end
      drive(32'h0, 1, 9, 0, 0, 0, 0);
      commit();
    end
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; clr_stats = 1'b0;
    bi0.pred_pc = '0; bi0.upd_valid = 1'b0; bi0.upd_idx = '0;
    bi0.upd_taken = 1'b0; bi0.upd_mispredict = 1'b0;
    model_reset();
    test_reset();
    test_stall();
    test_saturation();
    test_collision();
    test_stats();
    test_gshare();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/branch_predictor_table.md
Name: branch_predictor_table

Overview:
- PC-indexed table of 2^IDX_W saturating counters, each CTR_W bits wide.
- Two indexing modes: bimodal (PC only) or gshare (PC XOR global history).
- Successor to the single-counter predictor. Sits beside IF: gives a same-cycle taken/not-taken prediction and takes resolved-branch updates from EX.
- After reset, an init sweep loads every entry, one per cycle. The block also keeps saturating branch and mispredict statistics.

Parameters:
- PC_W, 32, program counter width.
- IDX_W, 6, table index width; table holds 2^IDX_W entries.
- CTR_W, 2, counter width; legal range 2..4.
- GHR_W, 6, global history length; must be ≤ IDX_W.
- MODE, 0, index mode: 0 = bimodal, 1 = gshare.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- stall  in  1  pipeline stall; blocks updates and history shift
- pred_pc  in  PC_W  PC of the instruction in IF
- pred_taken  out  1  prediction: 1 = taken
- pred_idx  out  IDX_W  table index used; the pipeline carries it to EX
- upd_valid  in  1  a resolved branch is present in EX
- upd_idx  in  IDX_W  pred_idx captured when that branch was predicted
- upd_taken  in  1  actual branch outcome
- upd_mispredict  in  1  the prediction for that branch was wrong
- clr_stats  in  1  clear the statistics counters
- init_busy  out  1  init sweep in progress
- br_cnt  out  CNT_W  count of resolved branches
- mis_cnt  out  CNT_W  count of mispredictions

Behaviour:
- One clock; reset is synchronous and active-high.
- Index computation:
  - idx = pred_pc[IDX_W+1:2] when MODE=0.
  - idx = pred_pc[IDX_W+1:2] XOR zero-extended ghr when MODE=1.
  - pred_idx = idx, purely combinational.
- Prediction output:
  - pred_taken = MSB of table[idx], combinational, zero-cycle latency.
  - pred_taken is forced to 0 while init_busy=1.
- Reset state: ghr=0, br_cnt=0, mis_cnt=0. FSM enters INIT with sweep pointer=0, so init_busy=1 in the first cycle after reset.
- Init sweep, FSM states INIT and RUN:
  - INIT writes table[ptr] = 2^(CTR_W-1)-1, i.e. weakly not-taken (01 for CTR_W=2), then increments ptr.
  - After writing entry 2^IDX_W-1, the FSM moves to RUN on the next edge. init_busy is therefore high for exactly 2^IDX_W cycles.
  - rst asserted in either state restarts INIT at ptr=0.
  - Updates and statistics are ignored while in INIT.
- Counter update, in RUN when upd_valid=1 and stall=0, at the next posedge:
  - upd_taken=1: table[upd_idx] increments, saturating at 2^CTR_W-1.
  - upd_taken=0: table[upd_idx] decrements, saturating at 0.
  - The new value is visible to pred_taken on the following cycle.
- History update, same qualifying condition:
  - ghr <= {ghr[GHR_W-2:0], upd_taken}.
  - Non-speculative: the history shifts only on resolve.
  - Under MODE=0 the ghr is still maintained but unused.
- Read/write collision: when prediction and update hit the same index in the same cycle, pred_taken reflects the pre-update value. There is no bypass.
- Statistics:
  - On a qualifying update, br_cnt increments; mis_cnt also increments if upd_mispredict=1.
  - Both counters saturate at all-ones and never wrap.
  - clr_stats=1 zeroes both counters and takes priority over a simultaneous increment.
- stall=1: table, ghr and statistics all hold. pred_taken and pred_idx stay combinational.
- upd_valid=0 or stall=1: no state change other than the INIT sweep. The sweep is not gated by stall.

Test Plan:
- Reset init:
  - Stimulus: assert rst 1 cycle, defaults.
  - Required: init_busy=1 for exactly 64 cycles and pred_taken=0 throughout.
  - After the sweep, every entry reads 01 (check via 64 pred_pc values): pred_taken=0.
- Saturation, MODE=0:
  - Stimulus: pred_pc=0x40, idx=16. Apply 3 taken updates to idx 16.
  - Required: pred_taken 0→1 after the 1st update (01→10). The counter reaches 11 and stays at 11 after a 4th taken update.
  - Then 4 not-taken updates: counter reaches 00. A further not-taken update leaves it at 00.
- Stall gating:
  - Stimulus: upd_valid=1, upd_taken=1, stall=1 for 5 cycles on idx 3.
  - Required: no change to idx 3 (pred_taken=0), br_cnt=0, ghr=0.
- Collision:
  - Stimulus: same cycle pred_pc→idx 5 and taken update to idx 5, which was at 01.
  - Required: pred_taken=0 that cycle, 1 the next.
- gshare indexing, MODE=1:
  - Stimulus: taken updates produce ghr=000011; then pred_pc=0x40.
  - Required: pred_idx = 16 XOR 3 = 19.
  - Mid-init rst: reapplying rst at sweep cycle 30 restarts the sweep; init_busy stays high for 64 more cycles.
- Statistics, CNT_W=4:
  - Stimulus: 20 updates, 7 of them with upd_mispredict=1.
  - Required: br_cnt=15 (saturated), mis_cnt=7.
  - clr_stats together with a valid update: both counters read 0 the next cycle.
